// File: rtl/cpu_param.sv
// cpu_param: parametrised multi-cycle CPU core with two-byte instructions.
// Each instruction is an opcode/rd byte followed by a DATA_W-wide operand K.
// Memory is reached through a registered req/ready handshake.
// Optional feature macro: CPU_DEBUG_PORT_EN adds a register peek port
// (dbg_sel/dbg_data) and a retired-instruction counter (retired).
module cpu_param #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 8,
    parameter int NREG   = 8
) (
    input  logic              clk,
    input  logic              reset,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_ready,
    output logic [ADDR_W-1:0] ip,
    output logic              halted,
    output logic              error
`ifdef CPU_DEBUG_PORT_EN
    ,
    input  logic [3:0]        dbg_sel,
    output logic [DATA_W-1:0] dbg_data,
    output logic [31:0]       retired
`endif
);

    localparam logic [3:0] OP_LDI  = 4'h1;
    localparam logic [3:0] OP_LD   = 4'h2;
    localparam logic [3:0] OP_ST   = 4'h3;
    localparam logic [3:0] OP_ADD  = 4'h4;
    localparam logic [3:0] OP_JMP  = 4'h5;
    localparam logic [3:0] OP_JZ   = 4'h6;
    localparam logic [3:0] OP_HALT = 4'hF;

    typedef enum logic [2:0] {
        S_FETCH_OP,
        S_WAIT_OP,
        S_FETCH_ARG,
        S_WAIT_ARG,
        S_EXEC,
        S_MEM_WAIT,
        S_HALT,
        S_ERROR
    } state_t;

    state_t             state_q;
    logic               mem_req_q;
    logic               mem_we_q;
    logic [ADDR_W-1:0]  mem_addr_q;
    logic [DATA_W-1:0]  mem_wdata_q;
    logic [ADDR_W-1:0]  ip_q;
    logic               halted_q;
    logic               error_q;
    logic [7:0]         instr_q;
    logic [DATA_W-1:0]  k_q;
    logic               z_q;
    // Sized to the full 4-bit index space; entries at or above NREG are
    // never written, so they stay at zero and fold away.
    logic [DATA_W-1:0]  regs_q [16];

    logic [3:0]         op;
    logic [3:0]         rd;
    logic [3:0]         rs;
    logic [ADDR_W-1:0]  k_addr_d;
    logic [ADDR_W-1:0]  ip_inc1_d;
    logic [ADDR_W-1:0]  ip_inc2_d;
    logic [DATA_W-1:0]  sum_d;
    logic               op_legal_d;
    logic               uses_rd_d;
    logic               fault_d;

    assign op        = instr_q[7:4];
    assign rd        = instr_q[3:0];
    assign rs        = k_q[3:0];

    assign mem_req   = mem_req_q;
    assign mem_we    = mem_we_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;
    assign ip        = ip_q;
    assign halted    = halted_q;
    assign error     = error_q;

    // Decode helpers: sequential ip values, adder result and fault detection.
    always_comb begin
        k_addr_d   = ADDR_W'(k_q);
        ip_inc1_d  = ip_q + ADDR_W'(1);
        ip_inc2_d  = ip_q + ADDR_W'(2);
        sum_d      = regs_q[rd] + regs_q[rs];
        op_legal_d = (op == OP_LDI) || (op == OP_LD) || (op == OP_ST) ||
                     (op == OP_ADD) || (op == OP_JMP) || (op == OP_JZ) ||
                     (op == OP_HALT);
        uses_rd_d  = (op == OP_LDI) || (op == OP_LD) || (op == OP_ST) ||
                     (op == OP_ADD);
        fault_d    = !op_legal_d ||
                     (uses_rd_d && (int'(rd) >= NREG)) ||
                     ((op == OP_ADD) && (int'(rs) >= NREG));
    end

    // Main control FSM: fetch, operand fetch, execute and load/store access.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= S_FETCH_OP;
            mem_req_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            ip_q        <= '0;
            halted_q    <= 1'b0;
            error_q     <= 1'b0;
            instr_q     <= '0;
            k_q         <= '0;
            z_q         <= 1'b1;
            for (int i = 0; i < 16; i++) begin
                regs_q[i] <= '0;
            end
        end else begin
            case (state_q)
                S_FETCH_OP: begin
                    mem_req_q  <= 1'b1;
                    mem_we_q   <= 1'b0;
                    mem_addr_q <= ip_q;
                    state_q    <= S_WAIT_OP;
                end
                S_WAIT_OP: begin
                    if (mem_ready) begin
                        mem_req_q <= 1'b0;
                        instr_q   <= mem_rdata[7:0];
                        state_q   <= S_FETCH_ARG;
                    end
                end
                S_FETCH_ARG: begin
                    mem_req_q  <= 1'b1;
                    mem_we_q   <= 1'b0;
                    mem_addr_q <= ip_inc1_d;
                    state_q    <= S_WAIT_ARG;
                end
                S_WAIT_ARG: begin
                    if (mem_ready) begin
                        mem_req_q <= 1'b0;
                        k_q       <= mem_rdata;
                        state_q   <= S_EXEC;
                    end
                end
                S_EXEC: begin
                    if (fault_d) begin
                        // Faulting instruction leaves ip and registers untouched.
                        halted_q <= 1'b1;
                        error_q  <= 1'b1;
                        state_q  <= S_ERROR;
                    end else begin
                        case (op)
                            OP_LDI: begin
                                regs_q[rd] <= k_q;
                                z_q        <= (k_q == '0);
                                ip_q       <= ip_inc2_d;
                                state_q    <= S_FETCH_OP;
                            end
                            OP_LD: begin
                                mem_req_q  <= 1'b1;
                                mem_we_q   <= 1'b0;
                                mem_addr_q <= k_addr_d;
                                ip_q       <= ip_inc2_d;
                                state_q    <= S_MEM_WAIT;
                            end
                            OP_ST: begin
                                mem_req_q   <= 1'b1;
                                mem_we_q    <= 1'b1;
                                mem_addr_q  <= k_addr_d;
                                mem_wdata_q <= regs_q[rd];
                                ip_q        <= ip_inc2_d;
                                state_q     <= S_MEM_WAIT;
                            end
                            OP_ADD: begin
                                regs_q[rd] <= sum_d;
                                z_q        <= (sum_d == '0);
                                ip_q       <= ip_inc2_d;
                                state_q    <= S_FETCH_OP;
                            end
                            OP_JMP: begin
                                ip_q    <= k_addr_d;
                                state_q <= S_FETCH_OP;
                            end
                            OP_JZ: begin
                                ip_q    <= z_q ? k_addr_d : ip_inc2_d;
                                state_q <= S_FETCH_OP;
                            end
                            default: begin
                                // Only HALT reaches here once fault_d is clear.
                                halted_q <= 1'b1;
                                state_q  <= S_HALT;
                            end
                        endcase
                    end
                end
                S_MEM_WAIT: begin
                    if (mem_ready) begin
                        mem_req_q <= 1'b0;
                        mem_we_q  <= 1'b0;
                        if (!mem_we_q) begin
                            regs_q[rd] <= mem_rdata;
                            z_q        <= (mem_rdata == '0);
                        end
                        state_q <= S_FETCH_OP;
                    end
                end
                S_HALT: begin
                    mem_req_q <= 1'b0;
                end
                default: begin
                    mem_req_q <= 1'b0;
                    halted_q  <= 1'b1;
                    error_q   <= 1'b1;
                    state_q   <= S_ERROR;
                end
            endcase
        end
    end

`ifdef CPU_DEBUG_PORT_EN
    logic [31:0] retired_q;
    logic        retire_d;

    assign retired = retired_q;

    // Debug peek and retire pulse: non-memory ops retire in EXEC, loads/stores on completion.
    always_comb begin
        dbg_data = (int'(dbg_sel) < NREG) ? regs_q[dbg_sel] : '0;
        retire_d = ((state_q == S_EXEC) && !fault_d && (op != OP_LD) && (op != OP_ST)) ||
                   ((state_q == S_MEM_WAIT) && mem_ready);
    end

    // Free-running retired-instruction counter, wraps naturally.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            retired_q <= '0;
        end else if (retire_d) begin
            retired_q <= retired_q + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_cpu_param.sv
// Self-checking bench for cpu_param: table of ADD/ST/JZ programs plus
// hand-written sequences for stalls, faults, wrap-around and mid-access reset.
module tb_cpu_param;

    logic        clk;
    logic        reset;
    logic        mem_req;
    logic        mem_we;
    logic [7:0]  mem_addr;
    logic [7:0]  mem_wdata;
    logic [7:0]  mem_rdata;
    logic        mem_ready;
    logic [7:0]  ip;
    logic        halted;
    logic        error;
`ifdef CPU_DEBUG_PORT_EN
    logic [3:0]  dbg_sel;
    logic [7:0]  dbg_data;
    logic [31:0] retired;
    assign dbg_sel = 4'd0;
`endif

    cpu_param #(.DATA_W(8), .ADDR_W(8), .NREG(8)) dut (
        .clk       (clk),
        .reset     (reset),
        .mem_req   (mem_req),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata),
        .mem_ready (mem_ready),
        .ip        (ip),
        .halted    (halted),
        .error     (error)
`ifdef CPU_DEBUG_PORT_EN
        ,
        .dbg_sel   (dbg_sel),
        .dbg_data  (dbg_data),
        .retired   (retired)
`endif
    );

    typedef struct packed {
        logic [7:0] addr;
        logic [7:0] data;
    } wr_t;

    typedef struct {
        logic [7:0] a;
        logic [7:0] b;
        logic [7:0] sum;
        logic [7:0] ip_end;
    } vec_t;

    int         checks = 0;
    int         errors = 0;
    int         reads  = 0;
    int         writes = 0;
    logic       stall_mode = 1'b0;
    int         rdy_cnt = 0;
    logic [7:0] mem [256];
    wr_t        sb [$];

    logic       armed = 1'b0;
    logic [7:0] h_addr, h_wdata;
    logic       h_we;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    assign mem_rdata = mem[mem_addr];
    assign mem_ready = stall_mode ? (rdy_cnt == 3) : 1'b1;

    // Memory model: completes transactions, pops expected writes from the scoreboard.
    always @(posedge clk) begin
        if (reset && mem_req && mem_ready) begin
            if (mem_we) begin
                wr_t exp_w;
                writes++;
                checks++;
                if (sb.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_write: got addr=%0h data=%0h, none expected", mem_addr, mem_wdata);
                end else begin
                    exp_w = sb.pop_front();
                    if (mem_addr !== exp_w.addr || mem_wdata !== exp_w.data) begin
                        errors++;
                        $display("FAIL write: got addr=%0h data=%0h, expected addr=%0h data=%0h",
                                 mem_addr, mem_wdata, exp_w.addr, exp_w.data);
                    end
                end
                mem[mem_addr] = mem_wdata;
            end else begin
                reads++;
            end
        end
        if (!mem_req || mem_ready) rdy_cnt <= 0;
        else rdy_cnt <= rdy_cnt + 1;
    end

    // Stall monitor: a pending request must hold its outputs until it completes.
    always @(negedge clk) begin
        if (armed && reset) begin
            checks++;
            if (!mem_req || mem_addr !== h_addr || mem_we !== h_we || mem_wdata !== h_wdata) begin
                errors++;
                $display("FAIL stall_stable: got req=%0b addr=%0h we=%0b wdata=%0h, expected req=1 addr=%0h we=%0b wdata=%0h",
                         mem_req, mem_addr, mem_we, mem_wdata, h_addr, h_we, h_wdata);
            end
        end
        armed   = reset && mem_req && !mem_ready;
        h_addr  = mem_addr;
        h_we    = mem_we;
        h_wdata = mem_wdata;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic clear_mem();
        for (int i = 0; i < 256; i++) mem[i] = 8'h00;
        sb.delete();
    endtask

    task automatic put(input logic [7:0] addr, input logic [7:0] b0, input logic [7:0] b1);
        logic [7:0] a1;
        a1 = addr + 8'd1;
        mem[addr] = b0;
        mem[a1]   = b1;
    endtask

    task automatic expect_write(input logic [7:0] addr, input logic [7:0] data);
        wr_t w;
        w.addr = addr;
        w.data = data;
        sb.push_back(w);
    endtask

    task automatic start_cpu();
        @(negedge clk);
        reset = 1'b0;
        repeat (2) @(negedge clk);
        reads  = 0;
        writes = 0;
        reset  = 1'b1;
    endtask

    task automatic wait_halt(input string name, input int budget);
        int n = 0;
        while (!halted && n < budget) begin
            @(negedge clk);
            n++;
        end
        if (!halted) begin
            checks++;
            errors++;
            $display("FAIL %s_timeout: halted=0 after %0d cycles, expected halt", name, budget);
        end
    endtask

    task automatic check_quiet(input string name);
        int reqs = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (mem_req) reqs++;
        end
        check(name, reqs, 0);
    endtask

    vec_t vecs [5];

    initial begin
        reset = 1'b0;
        vecs[0] = '{a: 8'h05, b: 8'h07, sum: 8'h0C, ip_end: 8'h0A};
        vecs[1] = '{a: 8'hFF, b: 8'h01, sum: 8'h00, ip_end: 8'h20};
        vecs[2] = '{a: 8'h80, b: 8'h80, sum: 8'h00, ip_end: 8'h20};
        vecs[3] = '{a: 8'h12, b: 8'h34, sum: 8'h46, ip_end: 8'h0A};
        vecs[4] = '{a: 8'h00, b: 8'h00, sum: 8'h00, ip_end: 8'h20};
        clear_mem();

        // Reset state
        repeat (2) @(negedge clk);
        check("rst_req",    mem_req,   0);
        check("rst_we",     mem_we,    0);
        check("rst_addr",   mem_addr,  0);
        check("rst_wdata",  mem_wdata, 0);
        check("rst_ip",     ip,        0);
        check("rst_halted", halted,    0);
        check("rst_error",  error,     0);

        // LDI r0,5; LDI r1,7; ADD r0,r1; HALT
        clear_mem();
        put(8'h00, 8'h10, 8'h05);
        put(8'h02, 8'h11, 8'h07);
        put(8'h04, 8'h40, 8'h01);
        put(8'h06, 8'hF0, 8'h00);
        start_cpu();
        wait_halt("basic", 200);
        check("basic_ip",     ip,     8'h06);
        check("basic_halted", halted, 1);
        check("basic_error",  error,  0);
        check("basic_reads",  reads,  8);
        check_quiet("basic_quiet");

        // Table: LDI r0,a; LDI r1,b; ADD r0,r1; ST r0,[80]; JZ 20; HALT / 20: HALT
        for (int v = 0; v < 5; v++) begin
            clear_mem();
            put(8'h00, 8'h10, vecs[v].a);
            put(8'h02, 8'h11, vecs[v].b);
            put(8'h04, 8'h40, 8'h01);
            put(8'h06, 8'h30, 8'h80);
            put(8'h08, 8'h60, 8'h20);
            put(8'h0A, 8'hF0, 8'h00);
            put(8'h20, 8'hF0, 8'h00);
            expect_write(8'h80, vecs[v].sum);
            start_cpu();
            wait_halt($sformatf("vec%0d", v), 300);
            check($sformatf("vec%0d_ip", v),     ip,         vecs[v].ip_end);
            check($sformatf("vec%0d_error", v),  error,      0);
            check($sformatf("vec%0d_reads", v),  reads,      12);
            check($sformatf("vec%0d_writes", v), writes,     1);
            check($sformatf("vec%0d_sb", v),     sb.size(),  0);
        end

        // LD r2,[40] with 3 stall cycles per access, then ST r2,[81] to observe r2
        clear_mem();
        put(8'h00, 8'h22, 8'h40);
        put(8'h02, 8'h32, 8'h81);
        put(8'h04, 8'hF0, 8'h00);
        mem[8'h40] = 8'hA5;
        expect_write(8'h81, 8'hA5);
        stall_mode = 1'b1;
        start_cpu();
        wait_halt("ld_stall", 500);
        check("ld_ip",     ip,        8'h04);
        check("ld_reads",  reads,     7);
        check("ld_writes", writes,    1);
        check("ld_sb",     sb.size(), 0);
        stall_mode = 1'b0;

        // LDI r3,3C; ST r3,[80]; HALT
        clear_mem();
        put(8'h00, 8'h13, 8'h3C);
        put(8'h02, 8'h33, 8'h80);
        put(8'h04, 8'hF0, 8'h00);
        expect_write(8'h80, 8'h3C);
        start_cpu();
        wait_halt("st", 200);
        check("st_writes", writes,       1);
        check("st_sb",     sb.size(),    0);
        check("st_mem",    mem[8'h80],   8'h3C);
        check("st_ip",     ip,           8'h04);

        // JZ taken / not taken
        for (int t = 0; t < 2; t++) begin
            clear_mem();
            put(8'h00, 8'h10, (t == 0) ? 8'h00 : 8'h01);
            put(8'h02, 8'h60, 8'h10);
            put(8'h04, 8'hF0, 8'h00);
            put(8'h10, 8'hF0, 8'h00);
            start_cpu();
            wait_halt("jz", 200);
            check($sformatf("jz%0d_ip", t), ip, (t == 0) ? 8'h10 : 8'h04);
            check($sformatf("jz%0d_halted", t), halted, 1);
        end

        // Illegal opcode 0x7
        clear_mem();
        put(8'h00, 8'h70, 8'h00);
        start_cpu();
        wait_halt("badop", 200);
        check("badop_error",  error,  1);
        check("badop_halted", halted, 1);
        check("badop_ip",     ip,     8'h00);
        check("badop_reads",  reads,  2);
        check_quiet("badop_quiet");

        // Illegal register index r9 after one good instruction
        clear_mem();
        put(8'h00, 8'h10, 8'h01);
        put(8'h02, 8'h19, 8'h05);
        start_cpu();
        wait_halt("badreg", 200);
        check("badreg_error", error, 1);
        check("badreg_ip",    ip,    8'h02);
        check_quiet("badreg_quiet");

        // ip wrap: JZ F0 (Z=1 from reset); F0: JMP FF; FF: LDI r0 (K at 00); 01: HALT
        clear_mem();
        put(8'h00, 8'h60, 8'hF0);
        put(8'hF0, 8'h50, 8'hFF);
        mem[8'hFF] = 8'h10;
        start_cpu();
        wait_halt("wrap", 200);
        check("wrap_ip",    ip,    8'h01);
        check("wrap_error", error, 0);
        check("wrap_reads", reads, 8);

        // Reset asserted while the operand fetch is stalled
        clear_mem();
        put(8'h00, 8'h10, 8'h05);
        put(8'h02, 8'h11, 8'h07);
        put(8'h04, 8'h40, 8'h01);
        put(8'h06, 8'hF0, 8'h00);
        stall_mode = 1'b1;
        start_cpu();
        begin
            int n = 0;
            while (!(mem_req && mem_addr == 8'h01) && n < 100) begin
                @(negedge clk);
                n++;
            end
            check("mid_reached", (mem_req && mem_addr == 8'h01), 1);
        end
        reset = 1'b0;
        #1;
        check("mid_req_drop", mem_req, 0);
        check("mid_ip",       ip,      0);
        repeat (2) @(negedge clk);
        reset = 1'b1;
        begin
            int n = 0;
            while (!mem_req && n < 20) begin
                @(negedge clk);
                n++;
            end
            check("mid_restart_req",  mem_req,  1);
            check("mid_restart_addr", mem_addr, 8'h00);
        end
        wait_halt("mid", 500);
        check("mid_final_ip", ip, 8'h06);
        stall_mode = 1'b0;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/cpu_param.md
Name: cpu_param

Overview:
- Parametrised multi-cycle 2-byte-instruction CPU core.
- Successor to the fixed 8-bit fetch/execute core. Adds:
  - configurable data/address width and register count;
  - a ready-based memory handshake;
  - store, add, jump and conditional-jump instructions;
  - explicit halt/error reporting.
- Sits between the testbench/top level and a single-port memory model.

Parameters:
- DATA_W, 8, register/memory data width; must be >= 8.
- ADDR_W, 8, memory address and ip width.
- NREG, 8, number of general registers (1..16).

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-low reset.
- mem_req  output  1  memory transaction request.
- mem_we  output  1  1 = write, 0 = read; valid while mem_req.
- mem_addr  output  ADDR_W  transaction address.
- mem_wdata  output  DATA_W  write data.
- mem_rdata  input  DATA_W  read data; valid in the cycle mem_ready=1.
- mem_ready  input  1  transaction completes at a clk edge where mem_req=1 and mem_ready=1.
- ip  output  ADDR_W  address of the current instruction.
- halted  output  1  core stopped by HALT or error.
- error  output  1  illegal opcode or register index.

Behaviour:
- Reset (reset=0, asynchronous):
  - outputs: mem_req=0, mem_we=0, mem_addr=0, mem_wdata=0, ip=0, halted=0, error=0;
  - state=FETCH_OP; general registers cleared to 0; zero flag Z=1.
  - A reset asserted mid-transaction drops mem_req immediately; no partial register/ip update occurs.
- Instruction format:
  - byte0 at ip: [7:4] opcode, [3:0] rd; only the low 8 bits of the memory word are used.
  - byte1 at ip+1: operand K (full DATA_W).
  - Address operands use K[ADDR_W-1:0].
- Handshake:
  - mem_req, mem_we, mem_addr and mem_wdata are registered and stay stable until the completing edge.
  - mem_req deasserts in the cycle after completion.
  - Zero-wait memory (mem_ready tied 1) gives 2 cycles per access.
- States:
  - FETCH_OP: drive read of ip -> WAIT_OP.
  - WAIT_OP: on complete, latch instr -> FETCH_ARG.
  - FETCH_ARG: read ip+1 -> WAIT_ARG.
  - WAIT_ARG: on complete, latch K -> EXEC.
  - EXEC: decode; ip <= ip+2 unless jumping.
  - MEM_WAIT: load/store transaction; on complete -> FETCH_OP.
  - HALT: terminal; halted=1.
  - ERROR: terminal; halted=1, error=1.
- Opcodes:
  - 0x1 LDI: r[rd]<=K; Z<=(K==0).
  - 0x2 LD: read K -> r[rd]<=rdata; Z updated.
  - 0x3 ST: write r[rd] to K; Z unchanged.
  - 0x4 ADD: r[rd]<=r[rd]+r[K[3:0]] modulo 2^DATA_W (carry discarded); Z updated.
  - 0x5 JMP: ip<=K.
  - 0x6 JZ: ip<=K if Z else ip+2.
  - 0xF HALT: ip stays at the HALT instruction.
  - All other opcodes -> ERROR.
- Illegal register index: rd >= NREG (or ADD source >= NREG) -> ERROR, no state change; ip stays at the faulting instruction.
- Wrap-around: ip+1 and ip+2 wrap modulo 2^ADDR_W.
- Terminal states: HALT and ERROR are left only by reset; mem_req stays 0 in both.

Optional Feature:
- Macro CPU_DEBUG_PORT_EN.
- When defined, adds:
  - input dbg_sel [3:0];
  - output dbg_data [DATA_W-1:0] = r[dbg_sel], combinational, 0 if dbg_sel >= NREG;
  - output retired [31:0]: counts completed instructions (HALT counted, faults not); reset 0; wraps.
- Without the macro these ports do not exist; core behaviour is identical.

Test Plan:
- LDI r0,5; LDI r1,7; ADD r0,r1; HALT with mem_ready=1 -> r0=12, ip=6, halted=1, error=0, 8 memory reads total.
- LD r2,[0x40] with mem[0x40]=0xA5 and mem_ready low for 3 cycles on every access -> mem_addr/mem_req stable during the stalls; r2=0xA5.
- LDI r3,0x3C; ST r3,[0x80]; HALT -> one write, mem_we=1, mem_addr=0x80, mem_wdata=0x3C.
- LDI r0,0; JZ 0x10 with HALT at 0x10 -> ip=0x10, halted=1. Repeat with LDI r0,1 -> falls through to ip=4.
- Opcode 0x7, then separately LDI r9 with NREG=8 -> error=1, halted=1, ip unchanged, no further mem_req.
- Assert reset low mid-WAIT_ARG -> mem_req=0 in the same cycle; after release, ip=0, fetch restarts at address 0.
